thermal_tx_modulator: RTL and testbench
=======================================

// Module: thermal_tx_modulator
// PURPOSE
//  Parametrised thermal covert-channel transmitter. Accepts DATA_WIDTH-bit words over valid/ready and
//  sends each as a framed symbol stream: preamble, data MSB-first, then guard. The stream is sent by
//  gating NUM_BANKS toggling shift-register heater banks on or off for BIT_PERIOD cycles per symbol.
//  Sits between the payload source and the FPGA fabric; LEDs mirror channel state.
// PARAMETERS
//  NUM_BANKS      4        number of heater banks (>=1)
//  BANK_WIDTH     75       flops per bank (>=2)
//  DATA_WIDTH     8        payload bits per frame (>=1)
//  BIT_PERIOD     1000000  clk cycles per symbol (>=2; must be even when THERMAL_MANCHESTER_EN)
//  PREAMBLE_LEN   8        preamble symbols, alternating 1,0,1,0... starting with 1 (>=1)
//  GUARD_SYMBOLS  2        heat-off symbols after the data (>=1)
// PORTS
//  clk        in   1           system clock
//  reset      in   1           asynchronous, active-high reset
//  tx_valid   in   1           tx_data valid
//  tx_data    in   DATA_WIDTH  payload word
//  bank_en    in   NUM_BANKS   heater-bank enable mask, latched at accept
//  tx_ready   out  1           block idle; a word is accepted when tx_valid&&tx_ready at a posedge
//  busy       out  1           frame in progress
//  heat_on    out  1           current channel symbol level (1 = heating)
//  heat_mon   out  1           XOR-reduce of all bank flops (anti-optimisation tap)
//  led        out  4           {heat_on, busy, tx_ready, 1'b1}
// BEHAVIOUR
//  Reset (async): state IDLE, tx_ready=1, busy=0, heat_on=0, all bank flops=1, counters=0,
//   led=4'b0011, heat_mon=XOR of all-ones. Reset mid-frame aborts the frame; the word is lost.
//  FSM: IDLE -> PREAMBLE (on accept) -> DATA (after PREAMBLE_LEN symbols) -> GUARD (after DATA_WIDTH)
//   -> IDLE (after GUARD_SYMBOLS). In IDLE, tx_valid is ignored while tx_ready=0.
//  Accept edge: latch tx_data and bank_en. tx_ready->0, busy->1, and heat_on->first preamble symbol,
//   all registered at that same edge.
//  Symbol timing: period counter 0..BIT_PERIOD-1 ($clog2 width). Symbol index advances on wrap.
//   Each symbol holds exactly BIT_PERIOD cycles.
//   busy=1 for exactly (PREAMBLE_LEN+DATA_WIDTH+GUARD_SYMBOLS)*BIT_PERIOD cycles.
//   tx_ready=1 on the cycle after the last guard cycle.
//   Back-to-back: if tx_valid is held, the next accept occurs on the first ready cycle.
//   There is no gap beyond the guard.
//  Data bits are sent MSB first. Bit counter width is $clog2(DATA_WIDTH+1). Guard symbols are 0.
//  Heater bank i runs iff heat_on && bank_en_q[i]. Run: b[0]<=~b[W-1], b[W-1:1]<=b[W-2:0]
//   (Johnson toggle). Not running: hold value. Banks carry DONT_TOUCH and are never reset outside reset.
//  Input changes on tx_data/bank_en while busy have no effect.
// CONFIGURATION
//  THERMAL_MANCHESTER_EN defined: each symbol is split into two BIT_PERIOD/2 halves.
//   1 = heat then cool, 0 = cool then heat. Preamble and data are encoded this way.
//   Guard symbols stay 0/0 (unencoded). Frame length is unchanged.
//  THERMAL_MANCHESTER_EN undefined: on-off keying; heat_on equals the symbol for the whole period.
// STRUCTURE
//  Package thermal_tx_pkg holds: the state enum (IDLE, PREAMBLE, DATA, GUARD), the symbol-level
//   localparams, and the function preamble_bit(idx) = ~idx[0].
//  Sub-module heater_bank #(BANK_WIDTH) (clk, reset, run, mon) is instantiated NUM_BANKS times via
//   generate. mon = XOR-reduce of the bank.
// TESTING (BIT_PERIOD=4, DATA_WIDTH=8, PREAMBLE_LEN=4, GUARD_SYMBOLS=1, NUM_BANKS=2, BANK_WIDTH=4)
//  1 Reset released, no valid -> tx_ready=1, busy=0, heat_on=0, led=4'b0011 indefinitely, banks frozen.
//  2 Accept 8'hA5, bank_en=2'b11 (OOK) -> heat_on per 4-cycle symbol = 1010 10100101 0.
//    busy high 52 cycles, then tx_ready=1.
//  3 Accept 8'hFF, bank_en=2'b01 -> bank0 toggles only while heat_on. bank1 holds 4'b1111.
//    After 4 run cycles, bank0 = 4'b0000.
//  4 tx_valid held with 8'h01 then 8'h80 -> the second accept happens on the first tx_ready cycle
//    after the 52-cycle frame. tx_data changes mid-frame do not alter heat_on.
//  5 Assert reset at cycle 20 of a frame -> outputs return to their reset values immediately
//    (asynchronously). The next accept starts a clean preamble.
//  6 THERMAL_MANCHESTER_EN, data 8'h80 -> data bit7 = heat on 2 cycles then off 2 cycles.
//    Bits 6..0 = off 2 cycles then on 2 cycles each. Frame length is still 52 cycles.

Source files
------------

// File: rtl/thermal_tx_pkg.sv
// Shared types and helpers for the thermal covert-channel transmitter.
// Symbol levels, frame state enum and the preamble pattern function.
package thermal_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    GUARD
  } state_t;

  localparam logic SYM_HEAT = 1'b1;
  localparam logic SYM_COOL = 1'b0;

  function automatic logic preamble_bit(input logic [31:0] idx);
    return ~idx[0];
  endfunction

endpackage

// File: rtl/heater_bank.sv
// One Johnson-toggling heater bank; mon is the XOR of all its flops.
// The flops are kept from being optimised away and only reset by reset.
module heater_bank #(
  parameter int BANK_WIDTH = 75
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic mon
);

  (* DONT_TOUCH = "true" *) logic [BANK_WIDTH-1:0] b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b <= '1;
    end else if (run) begin
      b <= {b[BANK_WIDTH-2:0], ~b[BANK_WIDTH-1]};
    end
  end

  assign mon = ^b;

endmodule

// File: rtl/thermal_tx_modulator.sv
// Thermal covert-channel transmitter: preamble, MSB-first data, guard.
// Define THERMAL_MANCHESTER_EN for Manchester symbols instead of OOK.
module thermal_tx_modulator
  import thermal_tx_pkg::*;
#(
  parameter int NUM_BANKS     = 4,
  parameter int BANK_WIDTH    = 75,
  parameter int DATA_WIDTH    = 8,
  parameter int BIT_PERIOD    = 1000000,
  parameter int PREAMBLE_LEN  = 8,
  parameter int GUARD_SYMBOLS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic [NUM_BANKS-1:0]  bank_en,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  heat_on,
  output logic                  heat_mon,
  output logic [3:0]            led
);

  localparam int PW   = $clog2(BIT_PERIOD);
  localparam int BCW  = $clog2(DATA_WIDTH + 1);
  localparam int SMAX = (PREAMBLE_LEN > GUARD_SYMBOLS) ?
                        PREAMBLE_LEN : GUARD_SYMBOLS;
  localparam int SW   = $clog2(SMAX + 1);

  state_t                state, state_n;
  logic [PW-1:0]         per, per_n;
  logic [SW-1:0]         sym, sym_n;
  logic [BCW-1:0]        bits, bits_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic [NUM_BANKS-1:0]  en_q, en_n;
  logic [NUM_BANKS-1:0]  mon;
  logic                  wrap;
  logic                  active;
  logic                  sym_lvl;

  assign wrap = (per == PW'(BIT_PERIOD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      per    <= '0;
      sym    <= '0;
      bits   <= '0;
      data_q <= '0;
      en_q   <= '0;
    end else begin
      state  <= state_n;
      per    <= per_n;
      sym    <= sym_n;
      bits   <= bits_n;
      data_q <= data_n;
      en_q   <= en_n;
    end
  end

  always_comb begin
    state_n = state;
    per_n   = per;
    sym_n   = sym;
    bits_n  = bits;
    data_n  = data_q;
    en_n    = en_q;
    if (state != IDLE) begin
      per_n = wrap ? '0 : per + 1'b1;
    end
    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          state_n = PREAMBLE;
          per_n   = '0;
          sym_n   = '0;
          bits_n  = '0;
          data_n  = tx_data;
          en_n    = bank_en;
        end
      end
      PREAMBLE: begin
        if (wrap) begin
          if (sym == SW'(PREAMBLE_LEN - 1)) begin
            state_n = DATA;
            sym_n   = '0;
          end else begin
            sym_n = sym + 1'b1;
          end
        end
      end
      DATA: begin
        if (wrap) begin
          data_n = data_q << 1;
          bits_n = bits + 1'b1;
          if (bits == BCW'(DATA_WIDTH - 1)) begin
            state_n = GUARD;
            sym_n   = '0;
          end
        end
      end
      GUARD: begin
        if (wrap) begin
          if (sym == SW'(GUARD_SYMBOLS - 1)) begin
            state_n = IDLE;
          end else begin
            sym_n = sym + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sym_lvl = SYM_COOL;
    unique case (state)
      PREAMBLE: sym_lvl = preamble_bit(32'(sym));
      DATA:     sym_lvl = data_q[DATA_WIDTH-1];
      default:  sym_lvl = SYM_COOL;
    endcase
  end

  assign active = (state == PREAMBLE) || (state == DATA);

`ifdef THERMAL_MANCHESTER_EN
  logic first_half;
  // 1 heats in the first half, 0 in the second; guard stays cold
  assign first_half = (per < PW'(BIT_PERIOD / 2));
  assign heat_on = active && (sym_lvl ? first_half : !first_half);
`else
  assign heat_on = active && sym_lvl;
`endif

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign led      = {heat_on, busy, tx_ready, 1'b1};

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    heater_bank #(
      .BANK_WIDTH(BANK_WIDTH)
    ) u_bank (
      .clk  (clk),
      .reset(reset),
      .run  (heat_on && en_q[i]),
      .mon  (mon[i])
    );
  end

  assign heat_mon = ^mon;

endmodule

// File: tb/tb_thermal_tx_modulator.sv
// Randomised self-checking bench for thermal_tx_modulator.
// Reference model derives symbol levels from the frame layout.
module tb_thermal_tx_modulator;

  localparam int BP    = 4;
  localparam int DW    = 8;
  localparam int PL    = 4;
  localparam int GS    = 1;
  localparam int NB    = 2;
  localparam int BW    = 4;
  localparam int FRAME = (PL + DW + GS) * BP;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic [NB-1:0] bank_en;
  logic          tx_ready;
  logic          busy;
  logic          heat_on;
  logic          heat_mon;
  logic [3:0]    led;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int runs[NB];

  thermal_tx_modulator #(
    .NUM_BANKS    (NB),
    .BANK_WIDTH   (BW),
    .DATA_WIDTH   (DW),
    .BIT_PERIOD   (BP),
    .PREAMBLE_LEN (PL),
    .GUARD_SYMBOLS(GS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .bank_en (bank_en),
    .tx_ready(tx_ready),
    .busy    (busy),
    .heat_on (heat_on),
    .heat_mon(heat_mon),
    .led     (led)
  );

  always #5 clk = ~clk;

  // Expected heat level at cycle k of a frame carrying word d
  function automatic logic exp_heat(input logic [DW-1:0] d, input int k);
    int s, ph;
    logic lvl;
    s  = k / BP;
    ph = k % BP;
    if (s < PL) lvl = ((s % 2) == 0);
    else if (s < PL + DW) lvl = d[DW-1-(s-PL)];
    else return 1'b0;
`ifdef THERMAL_MANCHESTER_EN
    return lvl ? (ph < BP / 2) : (ph >= BP / 2);
`else
    return lvl;
`endif
  endfunction

  // Johnson counter contents after n steps from all-ones
  function automatic logic [BW-1:0] jpat(input int n);
    int k;
    logic [BW-1:0] ones;
    ones = '1;
    k = n % (2 * BW);
    if (k < BW) return ones << k;
    return ~(ones << (k - BW));
  endfunction

  task automatic pulse_reset();
    reset = 1'b1;
    tx_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NB; i++) runs[i] = 0;
  endtask

  task automatic run_frame(input logic [DW-1:0] d, input logic [NB-1:0] en,
                           input int ncyc, input bit hold,
                           input logic [DW-1:0] nd, input logic [NB-1:0] nen);
    logic e;
    logic [BW-1:0] b0, b1;
    tx_valid = 1'b1;
    tx_data  = d;
    bank_en  = en;
    @(posedge clk); #1;
    if (!hold) tx_valid = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      e  = exp_heat(d, k);
      b0 = jpat(runs[0]);
      b1 = jpat(runs[1]);
      chk_cnt++;
      if (heat_on !== e)
        $display("FAIL heat d=%h k=%0d got %b exp %b", d, k, heat_on, e);
      else pass_cnt++;
      chk_cnt++;
      if ({busy, tx_ready} !== 2'b10)
        $display("FAIL busy_ready d=%h k=%0d got %b exp 10", d, k, {busy, tx_ready});
      else pass_cnt++;
      chk_cnt++;
      if (led !== {e, 3'b101})
        $display("FAIL led d=%h k=%0d got %b exp %b", d, k, led, {e, 3'b101});
      else pass_cnt++;
      chk_cnt++;
      if (dut.g_bank[0].u_bank.b !== b0 || dut.g_bank[1].u_bank.b !== b1)
        $display("FAIL banks k=%0d got %b/%b exp %b/%b", k,
                 dut.g_bank[0].u_bank.b, dut.g_bank[1].u_bank.b, b0, b1);
      else pass_cnt++;
      chk_cnt++;
      if (heat_mon !== ((^b0) ^ (^b1)))
        $display("FAIL heat_mon k=%0d got %b exp %b", k, heat_mon, (^b0) ^ (^b1));
      else pass_cnt++;
      if (k == 5) begin
        tx_data = hold ? nd : DW'($urandom);
        bank_en = hold ? nen : NB'($urandom);
      end
      for (int i = 0; i < NB; i++)
        if (e && en[i]) runs[i]++;
      @(posedge clk); #1;
    end
    if (ncyc == FRAME) begin
      chk_cnt++;
      if ({tx_ready, busy, heat_on, led} !== 7'b1000011)
        $display("FAIL frame_end d=%h got rdy=%b busy=%b heat=%b led=%b exp 1 0 0 0011",
                 d, tx_ready, busy, heat_on, led);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    bank_en  = '0;
    for (int i = 0; i < NB; i++) runs[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({tx_ready, busy, heat_on, led} !== 7'b1000011)
      $display("FAIL in_reset got %b exp 1000011", {tx_ready, busy, heat_on, led});
    else pass_cnt++;
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk_cnt++;
      if ({tx_ready, busy, heat_on, led, heat_mon} !== 8'b10000110 ||
          dut.g_bank[0].u_bank.b !== 4'hF || dut.g_bank[1].u_bank.b !== 4'hF)
        $display("FAIL idle c=%0d got %b exp 10000110",
                 c, {tx_ready, busy, heat_on, led, heat_mon});
      else pass_cnt++;
    end
  endtask

  task automatic test_frame_a5();
    run_frame(8'hA5, 2'b11, FRAME, 1'b0, '0, '0);
  endtask

  task automatic test_bank_gate();
    logic [BW-1:0] exp0;
`ifdef THERMAL_MANCHESTER_EN
    exp0 = 4'b1100;
`else
    exp0 = 4'b0000;
`endif
    pulse_reset();
    run_frame(8'hFF, 2'b01, 4, 1'b0, '0, '0);
    chk_cnt++;
    if (dut.g_bank[0].u_bank.b !== exp0 || dut.g_bank[1].u_bank.b !== 4'hF)
      $display("FAIL bank_gate got %b/%b exp %b/1111",
               dut.g_bank[0].u_bank.b, dut.g_bank[1].u_bank.b, exp0);
    else pass_cnt++;
    pulse_reset();
  endtask

  task automatic test_back_to_back();
    run_frame(8'h01, 2'b10, FRAME, 1'b1, 8'h80, 2'b11);
    run_frame(8'h80, 2'b11, FRAME, 1'b0, '0, '0);
  endtask

  task automatic test_async_reset();
    run_frame(8'h5A, 2'b11, 20, 1'b0, '0, '0);
    #2;
    reset = 1'b1;
    #1;
    chk_cnt++;
    if ({tx_ready, busy, heat_on, led, heat_mon} !== 8'b10000110 ||
        dut.g_bank[0].u_bank.b !== 4'hF || dut.g_bank[1].u_bank.b !== 4'hF)
      $display("FAIL async_reset got %b exp 10000110",
               {tx_ready, busy, heat_on, led, heat_mon});
    else pass_cnt++;
    for (int i = 0; i < NB; i++) runs[i] = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    run_frame(8'h3C, 2'b10, FRAME, 1'b0, '0, '0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 5; f++)
      run_frame(DW'($urandom), NB'($urandom_range(1, 3)), FRAME, 1'b0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_bank_gate();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
